// File: rtl/div_seq_top.sv
// Sequential unsigned restoring divider: P / B -> quotient A, remainder R, one
// quotient bit per cycle, with valid/ready handshakes on operands and results.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | iterating, one quotient bit per edge, cnt counts 0..a_len-1
// DONE  | out_valid high, result held until out_ready
module div_seq_top #(
  parameter int a_len = 256,
  parameter int b_len = 64,
  parameter int p_len = a_len + b_len,
  parameter int cnt_w = $clog2(a_len)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [p_len-1:0] P,
  input  logic [b_len-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [a_len-1:0] A,
  output logic [b_len-1:0] R,
  output logic             div_zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [b_len-1:0] rem;
  logic [a_len-1:0] dvd;
  logic [b_len-1:0] dsr;
  logic [cnt_w-1:0] cnt;

  logic [b_len-1:0] p_hi;
  logic             b_zero;
  logic             p_ovf;
  logic             last;
  logic [b_len:0]   shifted;
  logic [b_len:0]   t;
  logic             q_bit;
  logic [b_len-1:0] rem_nx;
  logic [a_len-1:0] dvd_nx;

  assign p_hi   = P[p_len-1:a_len];
  assign b_zero = (B == '0);
  // A quotient wider than a_len bits exists exactly when the upper dividend part reaches B.
  assign p_ovf  = !b_zero && (p_hi >= B);
  assign last   = (cnt == cnt_w'(a_len - 1));

  // rem < dsr holds between iterations, so the b_len+1 bit difference never wraps
  // past its sign bit and t[b_len] alone tells a negative trial.
  assign shifted = {rem, dvd[a_len-1]};
  assign t       = shifted - {1'b0, dsr};
  assign q_bit   = !t[b_len];
  assign rem_nx  = q_bit ? t[b_len-1:0] : shifted[b_len-1:0];
  assign dvd_nx  = {dvd[a_len-2:0], q_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (b_zero || p_ovf) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      A        <= '0;
      R        <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        rem <= p_hi;
        dvd <= P[a_len-1:0];
        dsr <= B;
        cnt <= '0;
        // Error results skip CALC and load straight away.
        if (b_zero || p_ovf) begin
          A        <= '1;
          R        <= b_zero ? P[b_len-1:0] : '0;
          div_zero <= b_zero;
          ovf      <= p_ovf;
        end
      end else if (state == CALC) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          A        <= dvd_nx;
          R        <= rem_nx;
          div_zero <= 1'b0;
          ovf      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq_top.sv
// Bench for div_seq_top: a small 8/4 instance driven from a vector table and a
// default 256/64 instance checked against an arithmetic reference model.
module tb_div_seq_top;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // small instance: a_len=8, b_len=4
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_dz, s_ovf;
  logic [11:0] s_P;
  logic [3:0]  s_B, s_R;
  logic [7:0]  s_A;

  // default instance: a_len=256, b_len=64
  logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_dz, d_ovf;
  logic [319:0] d_P;
  logic [63:0]  d_B, d_R;
  logic [255:0] d_A;

  div_seq_top #(.a_len(8), .b_len(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .P(s_P), .B(s_B), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .A(s_A), .R(s_R), .div_zero(s_dz), .ovf(s_ovf)
  );

  div_seq_top u_big (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .P(d_P), .B(d_B), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .A(d_A), .R(d_R), .div_zero(d_dz), .ovf(d_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [329:0] got, input logic [329:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [11:0] p;
    logic [3:0]  b;
    logic [7:0]  a;
    logic [3:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: plain division; overflow means the true quotient needs more than 256 bits.
  function automatic void ref_div(input logic [319:0] p, input logic [63:0] b,
                                  output logic [255:0] a, output logic [63:0] r,
                                  output logic dz, output logic ov);
    logic [319:0] q, m;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 64'd0) begin
      dz = 1'b1;
      a  = '1;
      r  = p[63:0];
    end else begin
      q = p / {256'd0, b};
      m = p % {256'd0, b};
      if (q[319:256] != 64'd0) begin
        ov = 1'b1;
        a  = '1;
        r  = '0;
      end else begin
        a = q[255:0];
        r = m[63:0];
      end
    end
  endfunction

  // lat = rising edges after the accept edge until out_valid is seen high.
  task automatic small_op(input logic [11:0] p, input logic [3:0] b,
                          output logic [7:0] a, output logic [3:0] r,
                          output logic dz, output logic ov, output int lat);
    int n = 0;
    while (!s_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    s_P = p; s_B = b; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    a = s_A; r = s_R; dz = s_dz; ov = s_ovf;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  task automatic big_accept(input logic [319:0] p, input logic [63:0] b);
    int n = 0;
    while (!d_in_ready && n < 600) begin @(posedge clk); #1; n++; end
    d_P = p; d_B = b; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
  endtask

  task automatic big_wait(output int lat);
    lat = 0;
    while (!d_out_valid && lat < 600) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic big_op(input logic [319:0] p, input logic [63:0] b,
                        output logic [255:0] a, output logic [63:0] r,
                        output logic dz, output logic ov, output int lat);
    big_accept(p, b);
    big_wait(lat);
    a = d_A; r = d_R; dz = d_dz; ov = d_ovf;
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[10];
    logic [7:0]   sa;
    logic [3:0]   sr;
    logic         gdz, gov, edz, eov, bad;
    int           lat;
    logic [255:0] ga, ea, a0, a_first;
    logic [63:0]  gr, er, b0, r_first;
    logic [319:0] p, tmp;
    logic [63:0]  b;

    tbl[0] = '{12'h0FF, 4'd5,  8'd51,  4'd0,  1'b0, 1'b0, 8};
    tbl[1] = '{12'h500, 4'd5,  8'hFF,  4'd0,  1'b0, 1'b1, 0};
    tbl[2] = '{12'h123, 4'd0,  8'hFF,  4'h3,  1'b1, 1'b0, 0};
    tbl[3] = '{12'h000, 4'd3,  8'd0,   4'd0,  1'b0, 1'b0, 8};
    tbl[4] = '{12'hFFF, 4'hF,  8'hFF,  4'd0,  1'b0, 1'b1, 0};
    tbl[5] = '{12'h0EF, 4'hF,  8'd15,  4'd14, 1'b0, 1'b0, 8};
    tbl[6] = '{12'h4FF, 4'd5,  8'd255, 4'd4,  1'b0, 1'b0, 8};
    tbl[7] = '{12'h0FF, 4'd1,  8'd255, 4'd0,  1'b0, 1'b0, 8};
    tbl[8] = '{12'h3FF, 4'd4,  8'd255, 4'd3,  1'b0, 1'b0, 8};
    tbl[9] = '{12'h000, 4'd0,  8'hFF,  4'd0,  1'b1, 1'b0, 0};

    rst = 1'b1;
    s_in_valid = 0; s_out_ready = 0; s_P = '0; s_B = '0;
    d_in_valid = 0; d_out_ready = 0; d_P = '0; d_B = '0;
    #12;
    chk("reset_small", {s_in_ready, s_out_valid, s_A, s_R, s_dz, s_ovf}, {1'b1, 15'd0});
    chk("reset_big", {d_in_ready, d_out_valid, d_A, d_R, d_dz, d_ovf}, {1'b1, 323'd0});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // small instance vector table
    foreach (tbl[i]) begin
      small_op(tbl[i].p, tbl[i].b, sa, sr, gdz, gov, lat);
      chk($sformatf("tbl%0d_result", i), {gdz, gov, sa, sr}, {tbl[i].dz, tbl[i].ov, tbl[i].a, tbl[i].r});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_release", i), {s_in_ready, s_out_valid}, 2'b10);
    end

    // default instance: 1000/7 with ten cycles of backpressure
    big_accept(320'd1000, 64'd7);
    big_wait(lat);
    chk("bp_latency", lat, 256);
    chk("bp_result", {d_dz, d_ovf, d_A, d_R}, {2'b00, 256'd142, 64'd6});
    a_first = d_A; r_first = d_R; bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d_A !== a_first || d_R !== r_first || d_in_ready !== 1'b0 || d_out_valid !== 1'b1) bad = 1'b1;
    end
    chk("bp_hold_stable", bad, 1'b0);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    chk("bp_release", {d_in_ready, d_out_valid}, 2'b10);
    chk("bp_keep_result", {d_A, d_R}, {256'd142, 64'd6});

    // reset while iterating
    big_accept(320'd1000, 64'd7);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midcalc_reset", {d_in_ready, d_out_valid, d_A, d_R, d_dz, d_ovf}, {1'b1, 323'd0});
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    big_op(320'd1000, 64'd7, ga, gr, gdz, gov, lat);
    chk("after_reset_result", {gdz, gov, ga, gr}, {2'b00, 256'd142, 64'd6});

    // random operands against the reference model, mixing normal, overflow and zero divisor
    for (int i = 0; i < 24; i++) begin
      p = rand320();
      b = {$urandom, $urandom};
      if (i % 4 == 0) b = 64'd0;
      else if (i % 4 != 1) begin
        if (b == 64'd0) b = 64'd1;
        p[319:256] = b >> $urandom_range(1, 63);
      end
      big_op(p, b, ga, gr, gdz, gov, lat);
      ref_div(p, b, ea, er, edz, eov);
      chk($sformatf("rnd%0d_quot", i), {gdz, gov, ga}, {edz, eov, ea});
      chk($sformatf("rnd%0d_rem", i), gr, er);
      chk($sformatf("rnd%0d_latency", i), lat, (edz || eov) ? 0 : 256);
    end

    // round trip through multiplication
    for (int i = 0; i < 200; i++) begin
      tmp = rand320();
      a0 = tmp[255:0];
      a0[255] = 1'b0;
      b0 = {$urandom, $urandom};
      b0[63] = 1'b0;
      if (b0 == 64'd0) b0 = 64'd1;
      p = {64'd0, a0} * {256'd0, b0};
      big_op(p, b0, ga, gr, gdz, gov, lat);
      chk($sformatf("rt%0d_quot", i), {gdz, gov, ga}, {2'b00, a0});
      chk($sformatf("rt%0d_rem", i), gr, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
